// File: rtl/uart_cmd_rx.sv
// UART 8N1 receiver with a 3-byte (opcode, A, B) command assembler feeding the ALU operand ports.
// Define CMD_CHECKSUM_EN to require a fourth byte (opcode_byte ^ A ^ B) before a command is committed.
module uart_cmd_rx #(
  parameter int CLKS_PER_BIT = 1250,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ena,
  input  logic       uart_rx,
  output logic [7:0] a,
  output logic [7:0] b,
  output logic [2:0] opcode,
  output logic       cmd_valid,
  output logic       cmd_err,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int CW     = $clog2(CLKS_PER_BIT);
  localparam int TO_CYC = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW     = $clog2(TO_CYC + 1);

  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TO_LIM  = TW'(TO_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  state_e          state_q, state_d;
  logic            rx_meta_q, rx_sync_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            stop_wait_q, stop_wait_d;
  logic [1:0]      idx_q, idx_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [2:0]      op_p_q, op_p_d;
  logic [7:0]      a_p_q, a_p_d;
`ifdef CMD_CHECKSUM_EN
  logic [7:0]      b_p_q, b_p_d;
`endif
  logic [7:0]      a_q, a_d, b_q, b_d;
  logic [2:0]      opcode_q, opcode_d;
  logic            cmd_valid_q, cmd_valid_d;
  logic            cmd_err_q, cmd_err_d;
  logic            frame_err_q, frame_err_d;
  logic            rx_busy_q, rx_busy_d;
  logic            byte_done;

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= uart_rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it unassigned and infers a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    stop_wait_d = stop_wait_q;
    idx_d       = idx_q;
    timer_d     = timer_q;
    op_p_d      = op_p_q;
    a_p_d       = a_p_q;
`ifdef CMD_CHECKSUM_EN
    b_p_d       = b_p_q;
`endif
    a_d         = a_q;
    b_d         = b_q;
    opcode_d    = opcode_q;
    cmd_valid_d = 1'b0;
    cmd_err_d   = 1'b0;
    frame_err_d = 1'b0;
    byte_done   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cnt_d       = '0;
        bit_idx_d   = '0;
        stop_wait_d = 1'b0;
        if (!rx_sync_q) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          state_d = rx_sync_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d     = '0;
          shift_d   = {rx_sync_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == 3'd7) state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (stop_wait_q) begin
          if (rx_sync_q) state_d = S_IDLE;
        end else if (cnt_q == FULL_M1) begin
          if (rx_sync_q) begin
            byte_done = 1'b1;
            state_d   = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            stop_wait_d = 1'b1;
            idx_d       = '0;
            timer_d     = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Byte completion takes priority over the inter-byte timeout.
    if (byte_done) begin
      timer_d = '0;
      unique case (idx_q)
        2'd0: begin
          if (shift_q[7:3] != 5'd0) begin
            cmd_err_d = 1'b1;
          end else begin
            op_p_d = shift_q[2:0];
            idx_d  = 2'd1;
          end
        end
        2'd1: begin
          a_p_d = shift_q;
          idx_d = 2'd2;
        end
`ifdef CMD_CHECKSUM_EN
        2'd2: begin
          b_p_d = shift_q;
          idx_d = 2'd3;
        end
        default: begin
          idx_d = '0;
          if (shift_q == ({5'd0, op_p_q} ^ a_p_q ^ b_p_q)) begin
            opcode_d    = op_p_q;
            a_d         = a_p_q;
            b_d         = b_p_q;
            cmd_valid_d = 1'b1;
          end else begin
            cmd_err_d = 1'b1;
          end
        end
`else
        default: begin
          idx_d       = '0;
          opcode_d    = op_p_q;
          a_d         = a_p_q;
          b_d         = shift_q;
          cmd_valid_d = 1'b1;
        end
`endif
      endcase
    end else if (state_q == S_IDLE && idx_q != 2'd0) begin
      if (timer_q == TO_LIM) begin
        idx_d     = '0;
        timer_d   = '0;
        cmd_err_d = 1'b1;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end

    // Disable drops any byte in flight but keeps the last committed operands.
    if (!ena) begin
      state_d     = S_IDLE;
      cnt_d       = '0;
      bit_idx_d   = '0;
      stop_wait_d = 1'b0;
      idx_d       = '0;
      timer_d     = '0;
      a_d         = a_q;
      b_d         = b_q;
      opcode_d    = opcode_q;
      cmd_valid_d = 1'b0;
      cmd_err_d   = 1'b0;
      frame_err_d = 1'b0;
    end

    rx_busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      stop_wait_q <= 1'b0;
      idx_q       <= '0;
      timer_q     <= '0;
      op_p_q      <= '0;
      a_p_q       <= '0;
`ifdef CMD_CHECKSUM_EN
      b_p_q       <= '0;
`endif
      a_q         <= '0;
      b_q         <= '0;
      opcode_q    <= '0;
      cmd_valid_q <= 1'b0;
      cmd_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
      rx_busy_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      stop_wait_q <= stop_wait_d;
      idx_q       <= idx_d;
      timer_q     <= timer_d;
      op_p_q      <= op_p_d;
      a_p_q       <= a_p_d;
`ifdef CMD_CHECKSUM_EN
      b_p_q       <= b_p_d;
`endif
      a_q         <= a_d;
      b_q         <= b_d;
      opcode_q    <= opcode_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_err_q   <= cmd_err_d;
      frame_err_q <= frame_err_d;
      rx_busy_q   <= rx_busy_d;
    end
  end

  assign a         = a_q;
  assign b         = b_q;
  assign opcode    = opcode_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd_err   = cmd_err_q;
  assign frame_err = frame_err_q;
  assign rx_busy   = rx_busy_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Scoreboard bench for uart_cmd_rx: expected commands are queued as frames are sent and popped on cmd_valid.
module tb_uart_cmd_rx;

  localparam int CPB = 16;
  localparam int TOB = 20;
`ifdef CMD_CHECKSUM_EN
  localparam int NB = 4;
`else
  localparam int NB = 3;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       ena = 1'b0;
  logic       uart_rx = 1'b1;
  logic [7:0] a, b;
  logic [2:0] opcode;
  logic       cmd_valid, cmd_err, frame_err, rx_busy;

  uart_cmd_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TOB)) dut (
    .clock(clock), .reset(reset), .ena(ena), .uart_rx(uart_rx),
    .a(a), .b(b), .opcode(opcode),
    .cmd_valid(cmd_valid), .cmd_err(cmd_err), .frame_err(frame_err), .rx_busy(rx_busy)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } cmd_t;

  cmd_t exp_q[$];
  cmd_t last_cmd = '0;
  cmd_t popped;
  int   checks = 0;
  int   errors = 0;
  int   n_valid = 0;
  int   n_cmd_err = 0;
  int   n_frame_err = 0;
  int   busy_hits = 0;

  // Output monitor: every cmd_valid must match the scoreboard head; otherwise outputs must hold.
  always @(negedge clock) begin
    if (!reset) begin
      last_cmd = '0;
    end else begin
      if (cmd_valid) begin
        n_valid++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_cmd_valid got op=%0d a=%0d b=%0d, none expected", opcode, a, b);
        end else begin
          popped = exp_q.pop_front();
          if ({opcode, a, b} !== popped) begin
            errors++;
            $display("FAIL cmd_payload got op=%0d a=%0d b=%0d expected op=%0d a=%0d b=%0d",
                     opcode, a, b, popped.op, popped.a, popped.b);
          end
        end
        last_cmd = {opcode, a, b};
      end else begin
        checks++;
        if ({opcode, a, b} !== last_cmd) begin
          errors++;
          $display("FAIL outputs_hold got op=%0d a=%0d b=%0d expected op=%0d a=%0d b=%0d",
                   opcode, a, b, last_cmd.op, last_cmd.a, last_cmd.b);
          last_cmd = {opcode, a, b};
        end
      end
      if (cmd_err)   n_cmd_err++;
      if (frame_err) n_frame_err++;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop = 1'b1);
    uart_rx = 1'b0;
    wait_cyc(CPB / 2);
    if (rx_busy) busy_hits++;
    wait_cyc(CPB - CPB / 2);
    for (int i = 0; i < 8; i++) begin
      uart_rx = d[i];
      wait_cyc(CPB);
    end
    uart_rx = stop;
    wait_cyc(CPB);
    uart_rx = 1'b1;
    wait_cyc(CPB + 4);
  endtask

  task automatic send_cmd(input logic [2:0] op, input logic [7:0] av, input logic [7:0] bv);
    send_byte({5'd0, op});
    send_byte(av);
    exp_q.push_back({op, av, bv});
    send_byte(bv);
`ifdef CMD_CHECKSUM_EN
    send_byte({5'd0, op} ^ av ^ bv);
`endif
  endtask

  task automatic check_int(input string name, input int got, input int expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, expv);
    end
  endtask

  task automatic check_outs(input string name, input cmd_t expv);
    checks++;
    if ({opcode, a, b} !== expv) begin
      errors++;
      $display("FAIL %s got op=%0d a=%0d b=%0d expected op=%0d a=%0d b=%0d",
               name, opcode, a, b, expv.op, expv.a, expv.b);
    end
  endtask

  task automatic test_reset();
    wait_cyc(3);
    checks++;
    if ({a, b, opcode, cmd_valid, cmd_err, frame_err, rx_busy} !== 23'd0) begin
      errors++;
      $display("FAIL reset_outputs got a=%0d b=%0d op=%0d v=%b ce=%b fe=%b busy=%b expected all 0",
               a, b, opcode, cmd_valid, cmd_err, frame_err, rx_busy);
    end
    reset = 1'b1;
    ena   = 1'b1;
    wait_cyc(5);
  endtask

  task automatic test_basic();
    int v0;
    v0 = n_valid;
    busy_hits = 0;
    send_cmd(3'd0, 8'h0F, 8'h0A);
    check_int("basic_valid_count", n_valid, v0 + 1);
    check_int("basic_busy_per_byte", busy_hits, NB);
    check_outs("basic_outputs", {3'd0, 8'd15, 8'd10});
  endtask

  task automatic test_back_to_back();
    int v0;
    v0 = n_valid;
    send_cmd(3'd2, 8'h0C, 8'h05);
    check_outs("b2b_first", {3'd2, 8'd12, 8'd5});
    send_cmd(3'd5, 8'h19, 8'h19);
    check_int("b2b_valid_count", n_valid, v0 + 2);
    check_outs("b2b_second", {3'd5, 8'd25, 8'd25});
  endtask

  task automatic test_glitch_and_frame();
    int v0, e0, f0;
    v0 = n_valid; e0 = n_cmd_err; f0 = n_frame_err;
    uart_rx = 1'b0;
    wait_cyc(4);
    uart_rx = 1'b1;
    wait_cyc(30);
    check_int("glitch_busy", int'(rx_busy), 0);
    check_int("glitch_no_flags", n_cmd_err + n_frame_err + n_valid, e0 + f0 + v0);
    send_byte(8'h55, 1'b0);
    check_int("frame_err_count", n_frame_err, f0 + 1);
    check_int("frame_err_no_cmd", n_valid + n_cmd_err, v0 + e0);
    check_outs("frame_err_held", {3'd5, 8'd25, 8'd25});
  endtask

  task automatic test_cmd_err_timeout();
    int v0, e0;
    v0 = n_valid; e0 = n_cmd_err;
    send_byte(8'h0A);
    check_int("bad_opcode_err", n_cmd_err, e0 + 1);
    send_byte(8'h01);
    check_int("no_early_timeout", n_cmd_err, e0 + 1);
    wait_cyc(400);
    check_int("timeout_err", n_cmd_err, e0 + 2);
    send_cmd(3'd3, 8'd100, 8'd7);
    check_int("after_timeout_valid", n_valid, v0 + 1);
    check_outs("after_timeout_outputs", {3'd3, 8'd100, 8'd7});
  endtask

  task automatic test_reset_mid_byte();
    int v0;
    send_byte(8'h01);
    send_byte(8'h11);
    fork
      send_byte(8'h22);
      begin
        wait_cyc(60);
        reset = 1'b0;
        #1;
        checks++;
        if ({a, b, opcode, cmd_valid, cmd_err, frame_err, rx_busy} !== 23'd0) begin
          errors++;
          $display("FAIL mid_reset_outputs got a=%0d b=%0d op=%0d busy=%b expected all 0",
                   a, b, opcode, rx_busy);
        end
      end
    join
    wait_cyc(5);
    reset = 1'b1;
    wait_cyc(5);
    v0 = n_valid;
    send_cmd(3'd4, 8'h33, 8'h44);
    check_int("post_reset_valid", n_valid, v0 + 1);
    check_outs("post_reset_outputs", {3'd4, 8'h33, 8'h44});
  endtask

  task automatic test_ena_drop();
    int v0;
    v0 = n_valid;
    send_byte(8'h01);
    send_byte(8'h21);
    fork
      send_byte(8'h31);
      begin
        wait_cyc(50);
        ena = 1'b0;
      end
    join
    wait_cyc(5);
    ena = 1'b1;
    wait_cyc(5);
    check_int("ena_no_valid", n_valid, v0);
    check_outs("ena_outputs_held", {3'd4, 8'h33, 8'h44});
    send_cmd(3'd6, 8'h77, 8'h88);
    check_int("ena_recover_valid", n_valid, v0 + 1);
  endtask

`ifdef CMD_CHECKSUM_EN
  task automatic test_checksum();
    int v0, e0;
    v0 = n_valid; e0 = n_cmd_err;
    send_cmd(3'd0, 8'h0F, 8'h0A);
    check_int("csum_good_valid", n_valid, v0 + 1);
    send_byte(8'h00);
    send_byte(8'h0F);
    send_byte(8'h0A);
    send_byte(8'h06);
    check_int("csum_bad_err", n_cmd_err, e0 + 1);
    check_int("csum_bad_no_valid", n_valid, v0 + 1);
    check_outs("csum_bad_held", {3'd0, 8'd15, 8'd10});
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_glitch_and_frame();
    test_cmd_err_timeout();
    test_reset_mid_byte();
    test_ena_drop();
`ifdef CMD_CHECKSUM_EN
    test_checksum();
`endif
    wait_cyc(20);
    check_int("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard bound so a stuck run still terminates.
  initial begin
    #2000000;
    $display("FAIL sim_timeout got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
